spi_lcd_tx: RTL and testbench



---
 rtl/spi_lcd_tx_pkg.sv | 27 ++
 rtl/spi_lcd_tx_fifo.sv | 49 ++++
 rtl/spi_lcd_tx.sv | 168 ++++++++++++++++
 tb/tb_spi_lcd_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_lcd_tx_pkg.sv
// rtl/spi_lcd_tx_pkg.sv - FSM states and FIFO entry layout shared by spi_lcd_tx and its bench
package spi_lcd_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // FIFO entry: {release, wide, dc, data[15:0]}
    localparam int ENTRY_W    = 19;
    localparam int F_DATA_LSB = 0;
    localparam int F_DC       = 16;
    localparam int F_WIDE     = 17;
    localparam int F_REL      = 18;

    localparam int DIV_W = 8;

    // 8-bit words are sent from the top byte so the shifter always starts at bit 15
    function automatic logic [15:0] align_word(input logic [15:0] data, input logic wide);
        return wide ? data : {data[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/spi_lcd_tx_fifo.sv
// rtl/spi_lcd_tx_fifo.sv - synchronous FIFO with registered level and ready
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     level_next,
    output logic                       not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && not_full;
    assign do_pop     = pop && (level != '0);
    assign level_next = level + LW'(do_push) - LW'(do_pop);
    assign rd_data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            not_full <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level    <= level_next;
            not_full <= (level_next != LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_lcd_tx.sv
// rtl/spi_lcd_tx.sv - SPI mode 0 LCD serialiser for 8/16-bit command and pixel words
module spi_lcd_tx
    import spi_lcd_tx_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int W_LEVEL    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [15:0]        in_data,
    input  logic               in_dc,
    input  logic               in_wide,
    input  logic               in_release,
    output logic               busy,
    output logic [W_LEVEL-1:0] level,
    output logic               lcd_cs,
    output logic               lcd_dc,
    output logic               lcd_sck,
    output logic               lcd_mosi
);

    localparam int                LW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0]  DIV_M1 = DIV_W'(CLK_DIV - 1);

    state_t             state, state_n;
    logic [DIV_W-1:0]   ctr, ctr_n;
    logic               sck_n, cs_n, dc_n, mosi_n, rel_r, rel_n, busy_n;
    logic [14:0]        sr, sr_n;
    logic [4:0]         bit_cnt, bit_cnt_n;
    logic               tick, pop, load, push, fifo_ne;
    logic [ENTRY_W-1:0] head;
    logic [LW-1:0]      fifo_level, fifo_level_next;
    logic [15:0]        load_word;

    assign push    = in_vld && in_rdy;
    assign fifo_ne = (fifo_level != '0);
    assign tick    = (ctr == DIV_M1);
    assign level   = W_LEVEL'(fifo_level);
    assign load_word = align_word(head[F_DATA_LSB +: 16], head[F_WIDE]);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .wr_data    ({in_release, in_wide, in_dc, in_data}),
        .pop        (pop),
        .rd_data    (head),
        .level      (fifo_level),
        .level_next (fifo_level_next),
        .not_full   (in_rdy)
    );

    always_comb begin
        state_n   = state;
        sck_n     = lcd_sck;
        cs_n      = lcd_cs;
        dc_n      = lcd_dc;
        mosi_n    = lcd_mosi;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        rel_n     = rel_r;
        pop       = 1'b0;
        load      = 1'b0;

        if (state == ST_IDLE || state == ST_PAUSE || tick) ctr_n = '0;
        else                                                ctr_n = ctr + DIV_W'(1);

        case (state)
            ST_IDLE: begin
                if (fifo_ne) begin
                    load    = 1'b1;
                    cs_n    = 1'b0;
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sck_n   = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick && !lcd_sck) begin
                    sck_n = 1'b1;
                end else if (tick) begin
                    sck_n = 1'b0;
                    if (bit_cnt > 5'd1) begin
                        mosi_n    = sr[14];
                        sr_n      = {sr[13:0], 1'b0};
                        bit_cnt_n = bit_cnt - 5'd1;
                    end else if (rel_r) begin
                        state_n = ST_HOLD;
                    end else if (fifo_ne) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (fifo_ne) begin
                    load    = 1'b1;
                    state_n = ST_SETUP;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_n      = 1'b1;
                    mosi_n    = 1'b0;
                    bit_cnt_n = 5'd2;
                    state_n   = ST_GAP;
                end
            end
            ST_GAP: begin
                // bit_cnt doubles as the CS-high tick counter here
                if (tick) begin
                    bit_cnt_n = bit_cnt - 5'd1;
                    if (bit_cnt == 5'd1) state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load) begin
            pop       = 1'b1;
            mosi_n    = load_word[15];
            sr_n      = load_word[14:0];
            dc_n      = head[F_DC];
            rel_n     = head[F_REL];
            bit_cnt_n = head[F_WIDE] ? 5'd16 : 5'd8;
        end

        busy_n = (state_n != ST_IDLE) || (fifo_level_next != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ctr      <= '0;
            lcd_sck  <= 1'b0;
            lcd_cs   <= 1'b1;
            lcd_dc   <= 1'b0;
            lcd_mosi <= 1'b0;
            sr       <= '0;
            bit_cnt  <= '0;
            rel_r    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ctr      <= ctr_n;
            lcd_sck  <= sck_n;
            lcd_cs   <= cs_n;
            lcd_dc   <= dc_n;
            lcd_mosi <= mosi_n;
            sr       <= sr_n;
            bit_cnt  <= bit_cnt_n;
            rel_r    <= rel_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_spi_lcd_tx.sv
// tb/tb_spi_lcd_tx.sv - scoreboard bench for spi_lcd_tx
module tb_spi_lcd_tx;
    import spi_lcd_tx_pkg::*;

    localparam int D     = 3;
    localparam int DEPTH = 4;
    localparam int WL    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [15:0]   in_data = '0;
    logic          in_dc = 1'b0;
    logic          in_wide = 1'b0;
    logic          in_release = 1'b0;
    logic          busy;
    logic [WL-1:0] level;
    logic          lcd_cs, lcd_dc, lcd_sck, lcd_mosi;

    spi_lcd_tx #(
        .CLK_DIV    (D),
        .FIFO_DEPTH (DEPTH),
        .W_LEVEL    (WL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .in_dc      (in_dc),
        .in_wide    (in_wide),
        .in_release (in_release),
        .busy       (busy),
        .level      (level),
        .lcd_cs     (lcd_cs),
        .lcd_dc     (lcd_dc),
        .lcd_sck    (lcd_sck),
        .lcd_mosi   (lcd_mosi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // scoreboard and monitor state
    logic [ENTRY_W-1:0] exp_q[$];
    logic [ENTRY_W-1:0] e;
    logic [15:0] cap = '0;
    logic        dc_bad = 1'b0;
    logic        p_cs = 1'b1, p_sck = 1'b0, p_dc = 1'b0;
    int cs_fall = 0, cs_rise = 0, s_first = 0, s_last = 0, s_lastfall = 0, s_rises = 0;
    int cap_n = 0, spurious = 0, dc_viol = 0, rdy_viol = 0, max_lvl = 0;
    int hs_cyc = 0;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            cap_n = 0;
            p_cs  = 1'b1;
            p_sck = 1'b0;
            p_dc  = 1'b0;
        end else begin
            if (level == WL'(DEPTH) && in_rdy) rdy_viol++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (p_cs && !lcd_cs) begin cs_fall = cyc; s_rises = 0; end
            if (!p_cs && lcd_cs) cs_rise = cyc;
            if (lcd_dc != p_dc && lcd_sck) dc_viol++;
            if (p_sck && !lcd_sck) s_lastfall = cyc;
            if (!p_sck && lcd_sck) begin
                if (s_rises == 0) s_first = cyc;
                s_last = cyc;
                s_rises++;
                if (lcd_cs || exp_q.size() == 0) begin
                    spurious++;
                end else begin
                    if (cap_n == 0) begin cap = '0; dc_bad = 1'b0; end
                    cap = {cap[14:0], lcd_mosi};
                    if (lcd_dc != exp_q[0][F_DC]) dc_bad = 1'b1;
                    cap_n++;
                    if (cap_n == (exp_q[0][F_WIDE] ? 16 : 8)) begin
                        e = exp_q.pop_front();
                        chk("word_data", 32'(cap), e[F_WIDE] ? 32'(e[15:0]) : 32'(e[7:0]));
                        chk("word_dc", 32'(dc_bad), 32'd0);
                        cap_n = 0;
                    end
                end
            end
            p_cs  = lcd_cs;
            p_sck = lcd_sck;
            p_dc  = lcd_dc;
        end
    end

    task automatic send(input logic [15:0] d, input logic dc, input logic wide, input logic rel);
        int budget = 2000;
        @(negedge clk);
        in_vld     = 1'b1;
        in_data    = d;
        in_dc      = dc;
        in_wide    = wide;
        in_release = rel;
        while (!in_rdy && budget > 0) begin
            chk("rdy_low_only_when_full", 32'(level), DEPTH);
            @(negedge clk);
            budget--;
        end
        chk("send_accepted", 32'(in_rdy), 32'd1);
        hs_cyc = cyc;
        exp_q.push_back({rel, wide, dc, d});
        @(posedge clk);
    endtask

    task automatic stop_send();
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget = 3000;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cs",   32'(lcd_cs),   32'd1);
        chk("rst_sck",  32'(lcd_sck),  32'd0);
        chk("rst_mosi", 32'(lcd_mosi), 32'd0);
        chk("rst_dc",   32'(lcd_dc),   32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_level", 32'(level),   32'd0);
        chk("rst_rdy",  32'(in_rdy),   32'd1);

        // single released word
        send(16'hA55A, 1'b1, 1'b1, 1'b1);
        stop_send();
        wait_idle("t1");
        chk("t1_cs_fall_lat",  32'(cs_fall - hs_cyc), 32'd2);
        chk("t1_first_rise",   32'(s_first - cs_fall), D);
        chk("t1_rises",        32'(s_rises), 32'd16);
        chk("t1_cs_rise",      32'(cs_rise - s_lastfall), D);
        chk("t1_cs_high",      32'(lcd_cs), 32'd1);

        // four gapless words, release on the last
        send(16'h8001, 1'b1, 1'b1, 1'b0);
        send(16'h7FFE, 1'b1, 1'b1, 1'b0);
        send(16'hC3C3, 1'b1, 1'b1, 1'b0);
        send(16'h0F0F, 1'b1, 1'b1, 1'b1);
        stop_send();
        wait_idle("t2");
        chk("t2_rises",   32'(s_rises), 32'd64);
        chk("t2_gapless", 32'(s_last - s_first), 63 * 2 * D);
        chk("t2_cs_rise", 32'(cs_rise - s_lastfall), D);

        // 8-bit command then 16-bit pixel
        send(16'h002C, 1'b0, 1'b0, 1'b0);
        send(16'hF800, 1'b1, 1'b1, 1'b1);
        stop_send();
        wait_idle("t3");
        chk("t3_rises",   32'(s_rises), 32'd24);
        chk("t3_gapless", 32'(s_last - s_first), 23 * 2 * D);

        // overfill the FIFO with in_vld held high
        for (int k = 1; k <= 6; k++) send(16'(k * 16'h1111), k[0], 1'b1, k == 6);
        stop_send();
        wait_idle("t4");
        chk("t4_max_level", 32'(max_lvl), DEPTH);
        chk("t4_rises",     32'(s_rises), 32'd96);

        // FIFO empties without release: PAUSE, then resume
        send(16'h3C5A, 1'b1, 1'b1, 1'b0);
        stop_send();
        b = 1000;
        while (exp_q.size() != 0 && b > 0) begin @(negedge clk); b--; end
        repeat (2 * D + 2) @(negedge clk);
        chk("t5_cs_low",  32'(lcd_cs),  32'd0);
        chk("t5_sck_low", 32'(lcd_sck), 32'd0);
        chk("t5_state",   32'(dut.state), 32'(ST_PAUSE));
        chk("t5_busy",    32'(busy),    32'd1);
        send(16'h00A5, 1'b0, 1'b0, 1'b1);
        stop_send();
        b = 200;
        while (!lcd_sck && b > 0) begin @(negedge clk); b--; end
        chk("t5_resume_rise", 32'(cyc - hs_cyc), D + 2);
        wait_idle("t5");

        // reset in the middle of a word
        send(16'hBEEF, 1'b1, 1'b1, 1'b1);
        stop_send();
        b = 500;
        while (cap_n < 8 && b > 0) begin @(posedge clk); b--; end
        chk("t6_reached_bit7", 32'(cap_n >= 8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_cs",    32'(lcd_cs),   32'd1);
        chk("t6_sck",   32'(lcd_sck),  32'd0);
        chk("t6_mosi",  32'(lcd_mosi), 32'd0);
        chk("t6_dc",    32'(lcd_dc),   32'd0);
        chk("t6_level", 32'(level),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(16'h1234, 1'b0, 1'b1, 1'b1);
        stop_send();
        wait_idle("t6");
        chk("t6_rises", 32'(s_rises), 32'd16);

        chk("spurious_bits",  32'(spurious), 32'd0);
        chk("dc_while_sck_high", 32'(dc_viol), 32'd0);
        chk("rdy_high_when_full", 32'(rdy_viol), 32'd0);
        chk("words_left",     32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
